sym_scorer: RTL and testbench

SYM_SCORER -- requirements
Module: sym_scorer

---
 rtl/sym_scorer.sv | 150 +++++++++++++++
 tb/tb_sym_scorer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sym_scorer.sv
// sym_scorer: reaction-game scoring block.
// A generator emits symbols; when one matches targetSym a response window of
// RESP_WINDOW cycles opens. A button press inside the window scores a hit.
// A window that runs out, or is replaced by a new target, scores a miss.
// A press while no window is open scores a false press.
// Ports:
//   Clk100M, rstN           clock, synchronous active-low reset
//   genSym                  game enable; 0 returns to IDLE
//   generated/generatedSym  new-symbol pulse and its code
//   targetSym               symbol the player must react to
//   button                  raw (debounced, asynchronous) press level
//   hits/misses/falsePress/targetCount  saturating score counters
//   lastSym                 most recent generated symbol (8'hFF after reset)
//   windowOpen              high while a response window is open
//   hitPulse/missPulse      one-cycle strobes, aligned with counter updates
module sym_scorer #(
    parameter int RESP_WINDOW = 100_000_000,
    parameter int CNT_W       = 16
) (
    input  logic             Clk100M,
    input  logic             rstN,
    input  logic             genSym,
    input  logic             generated,
    input  logic [7:0]       generatedSym,
    input  logic [7:0]       targetSym,
    input  logic             button,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] misses,
    output logic [CNT_W-1:0] falsePress,
    output logic [CNT_W-1:0] targetCount,
    output logic [7:0]       lastSym,
    output logic             windowOpen,
    output logic             hitPulse,
    output logic             missPulse
);
    localparam int TMR_W = $clog2(RESP_WINDOW);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RESP_WINDOW - 1);

    typedef enum logic [1:0] {IDLE, WAIT, WINDOW} state_t;

    state_t           state, stateN;
    logic [TMR_W-1:0] timer, timerN;
    logic [CNT_W-1:0] hitsN, missesN, falseN, tcN;
    logic [7:0]       lastSymN;
    logic             hitPulseN, missPulseN;
    logic             btnMeta, btnSync, btnPrev;
    logic             btnEdge, isTarget;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign btnEdge    = btnSync & ~btnPrev;
    assign isTarget   = generated && (generatedSym == targetSym);
    assign windowOpen = (state == WINDOW);

    always_comb begin
        stateN     = state;
        timerN     = timer;
        hitsN      = hits;
        missesN    = misses;
        falseN     = falsePress;
        tcN        = targetCount;
        lastSymN   = lastSym;
        hitPulseN  = 1'b0;
        missPulseN = 1'b0;
        // Dropping genSym abandons everything in flight; counters just hold.
        if (!genSym) begin
            stateN = IDLE;
        end else begin
            if (state != IDLE && generated)
                lastSymN = generatedSym;
            unique case (state)
                IDLE: begin
                    stateN  = WAIT;
                    hitsN   = '0;
                    missesN = '0;
                    falseN  = '0;
                    tcN     = '0;
                end
                WAIT: begin
                    // A press and a target in the same cycle both count.
                    if (btnEdge)
                        falseN = satInc(falsePress);
                    if (isTarget) begin
                        tcN    = satInc(targetCount);
                        timerN = TMR_LOAD;
                        stateN = WINDOW;
                    end
                end
                WINDOW: begin
                    if (timer != '0)
                        timerN = timer - TMR_W'(1);
                    if (btnEdge) begin
                        // A press always wins; a simultaneous target re-arms.
                        hitsN     = satInc(hits);
                        hitPulseN = 1'b1;
                        if (isTarget) begin
                            tcN    = satInc(targetCount);
                            timerN = TMR_LOAD;
                        end else begin
                            stateN = WAIT;
                        end
                    end else if (isTarget) begin
                        // Superseded window counts as a miss, new one starts.
                        missesN    = satInc(misses);
                        missPulseN = 1'b1;
                        tcN        = satInc(targetCount);
                        timerN     = TMR_LOAD;
                    end else if (timer == '0) begin
                        missesN    = satInc(misses);
                        missPulseN = 1'b1;
                        stateN     = WAIT;
                    end
                end
                default: stateN = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk100M) begin
        if (!rstN) begin
            state       <= IDLE;
            timer       <= '0;
            hits        <= '0;
            misses      <= '0;
            falsePress  <= '0;
            targetCount <= '0;
            lastSym     <= 8'hFF;
            hitPulse    <= 1'b0;
            missPulse   <= 1'b0;
            btnMeta     <= 1'b0;
            btnSync     <= 1'b0;
            btnPrev     <= 1'b0;
        end else begin
            state       <= stateN;
            timer       <= timerN;
            hits        <= hitsN;
            misses      <= missesN;
            falsePress  <= falseN;
            targetCount <= tcN;
            lastSym     <= lastSymN;
            hitPulse    <= hitPulseN;
            missPulse   <= missPulseN;
            btnMeta     <= button;
            btnSync     <= btnMeta;
            btnPrev     <= btnSync;
        end
    end
endmodule

// File: tb/tb_sym_scorer.sv
// Directed bench for sym_scorer (RESP_WINDOW=8). A second instance with
// CNT_W=3 exercises counter saturation in a short run.
module tb_sym_scorer;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rstN, genSym, generated, button;
    logic [7:0] generatedSym, targetSym;
    logic [CW-1:0] hits, misses, falsePress, targetCount;
    logic [7:0] lastSym;
    logic windowOpen, hitPulse, missPulse;

    logic genSym2, gen2, btn2;
    logic [7:0] gsym2, tsym2;
    logic [2:0] hits2, misses2, fp2, tc2;
    logic [7:0] lastSym2;
    logic wo2, hp2, mp2;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    sym_scorer #(.RESP_WINDOW(8), .CNT_W(CW)) dut (
        .Clk100M(clk), .rstN(rstN), .genSym(genSym), .generated(generated),
        .generatedSym(generatedSym), .targetSym(targetSym), .button(button),
        .hits(hits), .misses(misses), .falsePress(falsePress),
        .targetCount(targetCount), .lastSym(lastSym), .windowOpen(windowOpen),
        .hitPulse(hitPulse), .missPulse(missPulse)
    );

    sym_scorer #(.RESP_WINDOW(8), .CNT_W(3)) sat (
        .Clk100M(clk), .rstN(rstN), .genSym(genSym2), .generated(gen2),
        .generatedSym(gsym2), .targetSym(tsym2), .button(btn2),
        .hits(hits2), .misses(misses2), .falsePress(fp2),
        .targetCount(tc2), .lastSym(lastSym2), .windowOpen(wo2),
        .hitPulse(hp2), .missPulse(mp2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Let the button synchronizer settle, then start a fresh game.
    task automatic restart();
        step(3);
        genSym = 1'b0;
        step(1);
        genSym = 1'b1;
        step(1);
    endtask

    task automatic genTarget();
        generated    = 1'b1;
        generatedSym = 8'hEA;
        step(1);
        generated    = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rstN = 1'b0; genSym = 1'b0; generated = 1'b0; button = 1'b0;
        generatedSym = 8'h00; targetSym = 8'hEA;
        genSym2 = 1'b0; gen2 = 1'b0; btn2 = 1'b0; gsym2 = 8'h00; tsym2 = 8'h3C;
        step(3);
        chk("rst_hits", hits, 0);
        chk("rst_tc", targetCount, 0);
        chk("rst_lastSym", lastSym, 8'hFF);
        chk("rst_wo", windowOpen, 0);
        chk("rst_hp", hitPulse, 0);
        rstN = 1'b1;

        // Hit: press three cycles after the target opens the window.
        genSym = 1'b1;
        step(1);
        genTarget();
        chk("t1_tc", targetCount, 1);
        chk("t1_wo", windowOpen, 1);
        chk("t1_lastSym", lastSym, 8'hEA);
        step(2);
        button = 1'b1;
        step(3);
        chk("t1_hits", hits, 1);
        chk("t1_hp", hitPulse, 1);
        chk("t1_wo_after", windowOpen, 0);
        step(1);
        chk("t1_hp_once", hitPulse, 0);
        chk("t1_hits_hold", hits, 1);
        button = 1'b0;

        // Miss by timeout: window lasts exactly 8 cycles.
        restart();
        genTarget();
        n = 0;
        while (windowOpen && n < 20) begin
            n++;
            step(1);
        end
        chk("t2_wlen", n, 8);
        chk("t2_misses", misses, 1);
        chk("t2_mp", missPulse, 1);
        step(1);
        chk("t2_mp_once", missPulse, 0);
        chk("t2_hits", hits, 0);

        // False press in WAIT, then a non-target symbol.
        restart();
        button = 1'b1;
        step(3);
        chk("t3_fp", falsePress, 1);
        button = 1'b0;
        generated = 1'b1; generatedSym = 8'hF1;
        step(1);
        generated = 1'b0;
        chk("t3_lastSym", lastSym, 8'hF1);
        chk("t3_tc", targetCount, 0);
        chk("t3_wo", windowOpen, 0);

        // Two targets four cycles apart, no press.
        restart();
        genTarget();
        step(3);
        genTarget();
        chk("t4_misses1", misses, 1);
        chk("t4_mp", missPulse, 1);
        chk("t4_tc", targetCount, 2);
        chk("t4_wo", windowOpen, 1);
        n = 0;
        while (windowOpen && n < 20) begin
            n++;
            step(1);
        end
        chk("t4_wlen", n, 8);
        chk("t4_misses2", misses, 2);
        chk("t4_tc_final", targetCount, 2);

        // genSym dropped mid-window: no miss, counters hold, clear on re-raise.
        restart();
        genTarget();
        step(2);
        genSym = 1'b0;
        step(1);
        chk("t5_wo", windowOpen, 0);
        chk("t5_mp", missPulse, 0);
        step(10);
        chk("t5_misses", misses, 0);
        chk("t5_tc_hold", targetCount, 1);
        genSym = 1'b1;
        step(1);
        chk("t5_tc_clr", targetCount, 0);

        // Press and new target in the same WINDOW cycle.
        restart();
        genTarget();
        button = 1'b1;
        step(2);
        genTarget();
        chk("t6_hits", hits, 1);
        chk("t6_tc", targetCount, 2);
        chk("t6_wo", windowOpen, 1);
        chk("t6_misses", misses, 0);
        button = 1'b0;

        // Reset mid-window discards the window.
        restart();
        genTarget();
        rstN = 1'b0;
        step(1);
        chk("t7_wo_rst", windowOpen, 0);
        chk("t7_tc_rst", targetCount, 0);
        rstN = 1'b1;
        step(12);
        chk("t7_misses", misses, 0);
        chk("t7_wo", windowOpen, 0);
        chk("t7_lastSym", lastSym, 8'hFF);

        // Saturation on the 3-bit instance: nine hits, each re-arming.
        genSym2 = 1'b1;
        step(1);
        gen2 = 1'b1; gsym2 = 8'h3C;
        step(1);
        gen2 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            btn2 = 1'b1;
            step(2);
            gen2 = 1'b1;
            step(1);
            gen2 = 1'b0;
            btn2 = 1'b0;
            step(2);
        end
        chk("sat_hits", hits2, 7);
        chk("sat_tc", tc2, 7);
        chk("sat_misses", misses2, 0);
        chk("sat_wo", wo2, 1);
        rstN = 1'b0;
        step(1);
        rstN = 1'b1;
        chk("sat_rst_hits", hits2, 0);
        chk("sat_rst_tc", tc2, 0);
        chk("sat_rst_lastSym", lastSym2, 8'hFF);
        chk("sat_rst_main_hits", hits, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
